psg_bus_arb_rr: RTL and testbench

- Parametrised successor to the PSG wave-table bus arbiter.
- Grants one of NCH wave-table channel requesters the shared system bus.
- Re-arbitrates only on a clock-enabled bus acknowledge.
- Adds runtime fixed-priority / round-robin mode, a grant-valid flag and an owner-change pulse.
- Sits as one node of the PSG arbitration tree; its grant feeds the next level up as a single request.

---
 rtl/psg_bus_arb_rr.sv | 60 ++++++
 tb/tb_psg_bus_arb_rr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/psg_bus_arb_rr.sv
// rtl/psg_bus_arb_rr.sv - NCH-way bus arbiter, fixed-priority or round-robin, re-arbitrating on ce-qualified ack
module psg_bus_arb_rr #(
  parameter int NCH = 8,
  localparam int IDXW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            ack,
  input  logic [NCH-1:0]  req,
  input  logic            rr_mode,
  output logic [NCH-1:0]  sel,
  output logic [IDXW-1:0] seln,
  output logic            selv,
  output logic            grant_chg
);

  logic [IDXW-1:0] win;
  logic            found;
  int              start;
  int              idx;

  // Fixed priority is the round-robin search started at index 0; wrap is modulo NCH.
  always_comb begin
    win   = '0;
    found = 1'b0;
    start = 0;
    idx   = 0;
    if (rr_mode && selv)
      start = (int'(seln) == NCH - 1) ? 0 : int'(seln) + 1;
    for (int k = 0; k < NCH; k++) begin
      idx = start + k;
      if (idx >= NCH)
        idx = idx - NCH;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDXW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      seln      <= '0;
      selv      <= 1'b0;
      grant_chg <= 1'b0;
    end else begin
      grant_chg <= 1'b0;
      // With no requester the owner stays parked rather than released.
      if (ce && ack && found) begin
        sel       <= {{(NCH-1){1'b0}}, 1'b1} << win;
        seln      <= win;
        selv      <= 1'b1;
        grant_chg <= !selv || (win != seln);
      end
    end
  end

endmodule

// File: tb/tb_psg_bus_arb_rr.sv
// tb/tb_psg_bus_arb_rr.sv - directed bench for psg_bus_arb_rr with NCH=8 and NCH=6 instances
module tb_psg_bus_arb_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       ack;
  logic       rr_mode;
  logic [7:0] req;
  logic [5:0] req6;
  logic [7:0] sel;
  logic [2:0] seln;
  logic       selv;
  logic       grant_chg;
  logic [5:0] sel6;
  logic [2:0] seln6;
  logic       selv6;
  logic       grant_chg6;

  int total  = 0;
  int passed = 0;

  logic ev_cur  = 1'b0;
  logic ev_prev = 1'b0;
  logic gc_prev = 1'b0;

  always #5 clk = ~clk;

  psg_bus_arb_rr #(.NCH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack), .req(req), .rr_mode(rr_mode),
    .sel(sel), .seln(seln), .selv(selv), .grant_chg(grant_chg)
  );

  psg_bus_arb_rr #(.NCH(6)) dut6 (
    .clk(clk), .rst(rst), .ce(ce), .ack(ack), .req(req6), .rr_mode(rr_mode),
    .sel(sel6), .seln(seln6), .selv(selv6), .grant_chg(grant_chg6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    ev_prev <= ev_cur;
    ev_cur  <= ce && ack && !rst;
  end

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("inv_onehot0", {31'd0, $onehot0(sel)}, 32'd1);
      chk("inv_sel_selv", {31'd0, (sel == 8'd0)}, {31'd0, !selv});
      if (selv)
        chk("inv_sel_seln", {31'd0, sel[seln]}, 32'd1);
      if (grant_chg && gc_prev)
        chk("inv_gc_consec", {31'd0, ev_cur && ev_prev}, 32'd1);
    end
    gc_prev <= grant_chg;
  end

  initial begin
    rst = 1'b1; ce = 1'b0; ack = 1'b0; rr_mode = 1'b0; req = 8'h00; req6 = 6'h00;
    tick(); tick();
    chk("rst_sel", sel, 8'h00);
    chk("rst_seln", seln, 3'd0);
    chk("rst_selv", selv, 1'b0);
    chk("rst_gc", grant_chg, 1'b0);
    rst = 1'b0;

    ce = 1'b1; ack = 1'b1; req = 8'h00;
    tick();
    chk("noreq_sel", sel, 8'h00);
    chk("noreq_selv", selv, 1'b0);
    chk("noreq_gc", grant_chg, 1'b0);

    req = 8'b1010_0100;
    tick();
    chk("fix_sel", sel, 8'h04);
    chk("fix_seln", seln, 3'd2);
    chk("fix_selv", selv, 1'b1);
    chk("fix_gc", grant_chg, 1'b1);
    tick();
    chk("fix_rep_sel", sel, 8'h04);
    chk("fix_rep_gc", grant_chg, 1'b0);

    #2 rst = 1'b1;
    #1 chk("rst_mid_sel", sel, 8'h00);
    rst = 1'b0;
    rr_mode = 1'b1; req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rr_seln", seln, 32'(k % 8));
      chk("rr_sel", sel, 32'(8'h01 << (k % 8)));
      chk("rr_gc", grant_chg, 1'b1);
    end

    req = 8'h20; req6 = 6'b10_0000;
    tick();
    chk("to5_seln", seln, 3'd5);
    chk("to5_seln6", seln6, 3'd5);
    chk("to5_gc6", grant_chg6, 1'b1);
    req = 8'b0010_0001;
    tick();
    chk("wrap_seln", seln, 3'd0);
    chk("wrap_gc", grant_chg, 1'b1);
    chk("n6_stay_seln", seln6, 3'd5);
    chk("n6_stay_gc", grant_chg6, 1'b0);
    req6 = 6'b00_0011;
    tick();
    chk("n6_wrap_seln", seln6, 3'd0);
    chk("n6_wrap_sel", sel6, 6'h01);

    rr_mode = 1'b0; req = 8'h08;
    tick();
    chk("own3_sel", sel, 8'h08);
    for (int i = 0; i < 10; i++) begin
      ce  = i[0];
      ack = !i[0];
      req = 8'($urandom);
      tick();
      chk("hold_sel", sel, 8'h08);
      chk("hold_gc", grant_chg, 1'b0);
    end
    ce = 1'b1; ack = 1'b1; req = 8'h00;
    tick();
    chk("park_sel", sel, 8'h08);
    chk("park_selv", selv, 1'b1);
    chk("park_gc", grant_chg, 1'b0);

    rr_mode = 1'b1; req = 8'h0C;
    tick();
    chk("rr_owner_last", seln, 3'd2);
    chk("rr_owner_gc", grant_chg, 1'b1);

    rr_mode = 1'b0; req = 8'h10;
    tick();
    chk("own4_sel", sel, 8'h10);
    ce = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_sel", sel, 8'h00);
    chk("async_selv", selv, 1'b0);
    chk("async_gc", grant_chg, 1'b0);
    #1 rst = 1'b0;
    ce = 1'b1; rr_mode = 1'b1; req = 8'h81;
    tick();
    chk("post_rst_seln", seln, 3'd0);
    chk("post_rst_sel", sel, 8'h01);
    chk("post_rst_gc", grant_chg, 1'b1);

    ce = 1'b0; ack = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
